// File: rtl/bpsk_demod.sv
// bpsk_demod
// Recovers bits from a 1-bit BPSK waveform. Each sample is correlated against
// a local square-wave carrier. One bit is decided per symbol. Bits are packed
// LSB-first into a WORD_W-bit word, which is offered on a valid/ready handshake.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous reset, active low
//   bpsk_in      modulated waveform, sampled every clk
//   frame_start  1-cycle pulse; the next cycle carries sample 0 of bit 0
//   demod_ready  consumer can accept demod_data
//   demod_data   recovered word, bit 0 = first received bit
//   demod_valid  demod_data valid, held until accepted
//   busy         high while a word is being received
//   overrun      sticky, a completed word was dropped (output still occupied)
module bpsk_demod #(
    parameter int WORD_W          = 18,
    parameter int SAMPLES_PER_BIT = 16,
    parameter int CARRIER_DIV     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bpsk_in,
    input  logic              frame_start,
    input  logic              demod_ready,
    output logic [WORD_W-1:0] demod_data,
    output logic              demod_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int PH_W  = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam int SC_W  = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam int BC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int ACC_W = $clog2(SAMPLES_PER_BIT) + 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]              state;
    logic [PH_W-1:0]         phase_cnt;
    logic [SC_W-1:0]         sample_cnt;
    logic [BC_W-1:0]         bit_cnt;
    logic signed [ACC_W-1:0] acc;
    logic [WORD_W-1:0]       shreg;
    logic                    done_pend;

    logic                    carrier;
    logic signed [ACC_W-1:0] step;
    logic signed [ACC_W-1:0] acc_next;
    logic                    bit_dec;
    logic                    last_sample;
    logic                    last_bit;
    logic [WORD_W-1:0]       shift_next;

    // Correlation step: +1 when the sample agrees with the local carrier,
    // -1 otherwise. The decision includes the current sample, so it is taken
    // from the updated sum. A zero sum (tie) decodes as 0.
    always_comb begin
        carrier     = (phase_cnt < PH_W'(CARRIER_DIV / 2));
        step        = (bpsk_in == carrier) ? ACC_W'(1) : '1;
        acc_next    = acc + step;
        bit_dec     = !acc_next[ACC_W-1] && (acc_next != '0);
        last_sample = (sample_cnt == SC_W'(SAMPLES_PER_BIT - 1));
        last_bit    = (bit_cnt == BC_W'(WORD_W - 1));
        shift_next  = {bit_dec, shreg[WORD_W-1:1]};
    end

    assign busy = (state == RUN);

    // Output stage and receiver.
    // The completed word stays in shreg for one cycle and is loaded into the
    // output register on the following cycle. shreg is not cleared at
    // frame_start. A new word overwrites every bit of it, and the next shift
    // cannot occur before SAMPLES_PER_BIT cycles later. This makes it safe to
    // start a new frame in the same cycle that the previous word completes.
    // A frame_start is applied last so it overrides the counter updates. The
    // completion flag still survives, so a word finishing in that cycle is
    // delivered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            acc         <= '0;
            shreg       <= '0;
            done_pend   <= 1'b0;
            demod_data  <= '0;
            demod_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done_pend <= 1'b0;

            if (done_pend) begin
                if (!demod_valid || demod_ready) begin
                    demod_data  <= shreg;
                    demod_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (demod_valid && demod_ready) begin
                demod_valid <= 1'b0;
            end

            if (state == RUN) begin
                phase_cnt  <= (phase_cnt == PH_W'(CARRIER_DIV - 1)) ? '0 : phase_cnt + 1'b1;
                acc        <= acc_next;
                sample_cnt <= sample_cnt + 1'b1;
                if (last_sample) begin
                    shreg      <= shift_next;
                    acc        <= '0;
                    sample_cnt <= '0;
                    bit_cnt    <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        bit_cnt   <= '0;
                        done_pend <= 1'b1;
                        state     <= IDLE;
                    end
                end
            end

            if (frame_start) begin
                state      <= RUN;
                phase_cnt  <= '0;
                sample_cnt <= '0;
                bit_cnt    <= '0;
                acc        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bpsk_demod.sv
// tb_bpsk_demod
// Scoreboard bench for bpsk_demod. The stimulus process pushes each word it
// expects to be delivered. A monitor process pops that word and compares it
// on every valid&&ready transfer. Directed checks cover:
//   - reset state and exact latency
//   - noise tolerance and tie decoding
//   - overrun and back-to-back frames
//   - frame restart and asynchronous reset
module tb_bpsk_demod;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bpsk_in = 1'b0;
    logic        frame_start = 1'b0;
    logic        demod_ready = 1'b1;
    logic [17:0] demod_data;
    logic        demod_valid;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    bpsk_demod #(
        .WORD_W(18),
        .SAMPLES_PER_BIT(16),
        .CARRIER_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bpsk_in(bpsk_in),
        .frame_start(frame_start),
        .demod_ready(demod_ready),
        .demod_data(demod_data),
        .demod_valid(demod_valid),
        .busy(busy),
        .overrun(overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on each transfer, pop the expected word and compare it.
    always @(negedge clk) begin
        if (rst && demod_valid && demod_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h expected none at %0t", demod_data, $time);
            end else begin
                check("word", {14'd0, demod_data}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    // Drives nbits symbols of w, LSB first. A 1 is sent in phase with the
    // carrier and a 0 is sent inverted. The noisy option flips 3 samples per
    // symbol. The tie0 option inverts the first 8 samples of bit 0, giving a
    // zero sum. The fs_last option asserts frame_start on the final sample.
    task automatic send_bits(input logic [17:0] w, input int nbits, input bit noisy,
                             input bit tie0, input bit fs_last);
        for (int b = 0; b < nbits; b++) begin
            for (int s = 0; s < 16; s++) begin
                logic car;
                logic smp;
                car = ((s % 4) < 2);
                smp = w[b] ? car : ~car;
                if (noisy && (s == 1 || s == 6 || s == 11)) smp = ~smp;
                if (tie0 && b == 0 && s < 8) smp = ~smp;
                bpsk_in = smp;
                frame_start = fs_last && (b == nbits - 1) && (s == 15);
                @(posedge clk);
                #1;
            end
        end
        frame_start = 1'b0;
    endtask

    task automatic applyStimulus();
        // Reset state
        #12;
        check("rst_valid", {31'd0, demod_valid}, 32'd0);
        check("rst_data", {14'd0, demod_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_cycles(2);

        // Clean word with exact latency
        exp_q.push_back(18'h2A5A5);
        pulse_fs();
        check("busy_run", {31'd0, busy}, 32'd1);
        send_bits(18'h2A5A5, 18, 1'b0, 1'b0, 1'b0);
        check("valid_early", {31'd0, demod_valid}, 32'd0);
        wait_cycles(1);
        check("valid_latency", {31'd0, demod_valid}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
        wait_cycles(1);
        check("valid_drop", {31'd0, demod_valid}, 32'd0);

        // Noisy word, then tie on bit 0
        exp_q.push_back(18'h2A5A5);
        pulse_fs();
        send_bits(18'h2A5A5, 18, 1'b1, 1'b0, 1'b0);
        wait_cycles(3);
        exp_q.push_back(18'h2A5A4);
        pulse_fs();
        send_bits(18'h2A5A5, 18, 1'b0, 1'b1, 1'b0);
        wait_cycles(3);

        // Back-to-back frames, frame_start on the completion cycle
        exp_q.push_back(18'h3C3C3);
        exp_q.push_back(18'h0C3A5);
        pulse_fs();
        send_bits(18'h3C3C3, 18, 1'b0, 1'b0, 1'b1);
        send_bits(18'h0C3A5, 18, 1'b0, 1'b0, 1'b0);
        wait_cycles(3);
        check("b2b_overrun", {31'd0, overrun}, 32'd0);

        // Restart after 5 bits discards the partial word
        exp_q.push_back(18'h12345);
        pulse_fs();
        send_bits(18'h3FFFF, 5, 1'b0, 1'b0, 1'b0);
        pulse_fs();
        send_bits(18'h12345, 18, 1'b0, 1'b0, 1'b0);
        wait_cycles(3);
        check("restart_overrun", {31'd0, overrun}, 32'd0);

        // Overrun: the second word is dropped while the first is held
        demod_ready = 1'b0;
        exp_q.push_back(18'h3FFFF);
        pulse_fs();
        send_bits(18'h3FFFF, 18, 1'b0, 1'b0, 1'b0);
        pulse_fs();
        send_bits(18'h00001, 18, 1'b0, 1'b0, 1'b0);
        wait_cycles(2);
        check("ovr_data", {14'd0, demod_data}, 32'h3FFFF);
        check("ovr_valid", {31'd0, demod_valid}, 32'd1);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        demod_ready = 1'b1;
        wait_cycles(1);
        check("ovr_valid_drop", {31'd0, demod_valid}, 32'd0);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Async reset mid-RUN while a word is held
        demod_ready = 1'b0;
        pulse_fs();
        send_bits(18'h15555, 18, 1'b0, 1'b0, 1'b0);
        wait_cycles(1);
        pulse_fs();
        send_bits(18'h0AAAA, 3, 1'b0, 1'b0, 1'b0);
        check("pre_rst_valid", {31'd0, demod_valid}, 32'd1);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", {31'd0, demod_valid}, 32'd0);
        check("arst_data", {14'd0, demod_data}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        demod_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 50; j++) begin
                bpsk_in = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            check("idle_valid", {31'd0, demod_valid}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Normal operation after reset
        exp_q.push_back(18'h0F0F0);
        pulse_fs();
        send_bits(18'h0F0F0, 18, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        applyStimulus();
        checkOutput();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
